ib_voq: RTL and testbench
=========================

# ib_voq

Parametrised input buffer for one switch input port, the next generation of the single-FIFO input buffer. Incoming flits are sorted into one virtual output queue (VOQ) per destination port, so a packet blocked at one output does not stall packets for other outputs. Each queue requests its output from the arbiter independently. After a grant, the block streams that queue's packet, head to tail, onto the crossbar input as a wormhole connection.

## Interface
Parameters:
- `PKTW`, default 16: flit width W; W ≥ 2 + log2(NPORT).
- `NPORT`, default 4: number of output ports/VOQs; power of two, ≥ 2.
- `DEPTH`, default 8: flits per VOQ; power of two, ≥ 2.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `pkti`, in, W: input flit.
  - bits [W-1:W-2] are the flow code: 00 idle, 01 head, 10 body, 11 tail.
  - Head flit: bits [W-3 -: DW] carry the destination, with DW = log2(NPORT).
- `full`, out, 1: combinational; the queue targeted by the current `pkti` cannot accept it; upstream holds the flit.
- `we`, out, 1: combinational; `pkti` is written this cycle.
- `pkto`, out, W: registered output flit to the crossbar; idle (all zero) when nothing is sent.
- `req`, out, NPORT: per-output connection request.
- `ack`, in, NPORT: grant pulse from the output arbiter.
- `err`, out, 1: registered one-cycle pulse for a dropped orphan body/tail flit.

## Operation
Write side:
- Head flit: its destination is latched as `cur_dst`, and `dst_vld` is set.
- Body/tail flit: goes to `cur_dst`.
- Tail flit: clears `dst_vld` after it is written.
- Target queue for the current flit = head destination for a head flit, otherwise `cur_dst`.
- `full` = flit not idle, target queue count == DEPTH, and not an orphan.
- `we` = flit not idle, not full, not an orphan.
- Orphan = body/tail with `dst_vld` = 0. It is dropped, `err` pulses next cycle, and `full` = 0.
- A head arriving while `dst_vld` = 1 re-latches `cur_dst`. The truncated packet stays in its queue, unfixed.
- Full is judged on the registered count only. There is no same-cycle bypass of a pop.

Queues:
- NPORT circular FIFOs, each with log2(DEPTH)-bit read/write pointers (natural wrap) and a (log2(DEPTH)+1)-bit count.

Read side FSM:
- IDLE:
  - `req[i]` = queue i non-empty and its front flit is a head.
  - Grant is taken from `ack & req`: the lowest set bit i; if `ack & req` = 0, nothing happens.
  - On a grant: `sel` <= i, next state SEND.
  - `ack` bits without a matching `req` are ignored.
- SEND(sel):
  - `req` = one-hot(`sel`); the connection is held and `ack` is ignored.
  - Each cycle, if queue `sel` is non-empty: pop its front and register it to `pkto`.
  - If queue `sel` is empty: `pkto` <= idle (bubble) and the block stays in SEND.
  - Popping a tail flit: next state IDLE.
- A simultaneous write and pop on the same queue is legal: count is unchanged, both pointers advance.

## Timing
Reset (rst = 1 at an edge):
- All counts and pointers 0, `dst_vld` = 0, state IDLE.
- `pkto` = 0, `err` = 0.
- `req` = 0, since all queues are empty.
- `full` = `we` = 0 while queues are empty and `pkti` is idle.
- Reset mid-packet discards all queued flits and any open connection.

Latency and cycle behaviour:
- Write to queue occupancy: 1 cycle. A head written at edge t is visible on `req` in the cycle after t.
- Grant: `ack[i]` sampled at edge t gives SEND from t+1; the first pop happens at edge t+1; the head is on `pkto` after edge t+1.
- Streaming throughput: 1 flit/cycle while the queue is non-empty.
- Tail popped at edge u: `pkto` = tail and state IDLE after u. `req` is recomputed combinationally in IDLE; the same queue may be re-granted from the cycle after u.
- `pkto` returns to idle the cycle after the tail unless a new grant has already popped a head.

## Test plan
- Reset, then write head(dst 2) + body + tail with `ack` = 0: `we` = 1 for 3 cycles, `req` = 0100, `pkto` stays 0.
- From the previous state, pulse `ack` = 0100: head, body, tail appear on `pkto` on consecutive cycles starting 2 cycles after `ack`; `req` = 0000 after the tail.
- Fill VOQ 1 with 8 flits (DEPTH = 8), then offer a 9th flit to dst 1: `full` = 1, `we` = 0, flit held. A head to dst 3 the same cycle is accepted. No HOL blocking.
- Queues 0 and 3 both request, `ack` = 1001: queue 0 is served, `ack` is ignored during SEND, then queue 3 is served after re-grant.
- Stream a 4-flit packet while the writer stalls between flits: `pkto` shows idle bubbles; the connection holds until the tail.
- Body flit after reset with no head: `we` = 0, `full` = 0, `err` = 1 for one cycle. Assert `rst` mid-SEND: `pkto` = 0 and `req` = 0 next cycle.

Source files
------------

// File: rtl/ib_voq.sv
// Switch input buffer with one virtual output queue per destination port.
// Granted queues stream a whole packet onto the crossbar as a wormhole.
module ib_voq #(
    parameter int PKTW  = 16,
    parameter int NPORT = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PKTW-1:0]  pkti,
    output logic             full,
    output logic             we,
    output logic [PKTW-1:0]  pkto,
    output logic [NPORT-1:0] req,
    input  logic [NPORT-1:0] ack,
    output logic             err
);

    localparam int DW = $clog2(NPORT);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [1:0] FC_IDLE = 2'b00;
    localparam logic [1:0] FC_HEAD = 2'b01;
    localparam logic [1:0] FC_TAIL = 2'b11;

    typedef enum logic {IDLE, SEND} state_t;

    state_t state, state_nx;

    logic [PKTW-1:0] mem [NPORT][DEPTH];
    logic [AW-1:0]   rptr [NPORT];
    logic [AW-1:0]   wptr [NPORT];
    logic [AW:0]     cnt  [NPORT];

    logic [DW-1:0]    cur_dst, sel, tgt, gnt_idx;
    logic             dst_vld, orphan, pop, gnt_any;
    logic [1:0]       fc;
    logic [NPORT-1:0] heads, gnt, wr_q, rd_q;
    logic [PKTW-1:0]  front;

    // Write-side decode: orphans never stall upstream, they are just dropped
    always_comb begin
        fc     = pkti[PKTW-1 -: 2];
        tgt    = (fc == FC_HEAD) ? pkti[PKTW-3 -: DW] : cur_dst;
        orphan = (fc != FC_IDLE) && (fc != FC_HEAD) && !dst_vld;
        full   = (fc != FC_IDLE) && !orphan && (cnt[tgt] == CNT_MAX);
        we     = (fc != FC_IDLE) && !orphan && (cnt[tgt] != CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_dst <= '0;
            dst_vld <= 1'b0;
            err     <= 1'b0;
        end else begin
            err <= orphan;
            if (we) begin
                if (fc == FC_HEAD) begin
                    cur_dst <= pkti[PKTW-3 -: DW];
                    dst_vld <= 1'b1;
                end else if (fc == FC_TAIL) begin
                    dst_vld <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        front = mem[sel][rptr[sel]];
        pop   = (state == SEND) && (cnt[sel] != '0);
        for (int i = 0; i < NPORT; i++) begin
            heads[i] = (cnt[i] != '0) &&
                       (mem[i][rptr[i]][PKTW-1 -: 2] == FC_HEAD);
            wr_q[i]  = we && (tgt == DW'(i));
            rd_q[i]  = pop && (sel == DW'(i));
        end
    end

    // Lowest-index request wins among granted ones
    always_comb begin
        gnt     = ack & heads;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (gnt[i]) begin
                gnt_any = 1'b1;
                gnt_idx = DW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPORT; i++) begin
                rptr[i] <= '0;
                wptr[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NPORT; i++) begin
                if (wr_q[i])
                    wptr[i] <= wptr[i] + AW'(1);
                if (rd_q[i])
                    rptr[i] <= rptr[i] + AW'(1);
                cnt[i] <= cnt[i] + (AW+1)'(wr_q[i]) - (AW+1)'(rd_q[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[tgt][wptr[tgt]] <= pkti;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (gnt_any) state_nx = SEND;
            SEND: if (pop && front[PKTW-1 -: 2] == FC_TAIL) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req = '0;
        unique case (state)
            IDLE: req = heads;
            SEND: req[sel] = 1'b1;
            default: req = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel  <= '0;
            pkto <= '0;
        end else begin
            if (state == IDLE && gnt_any)
                sel <= gnt_idx;
            pkto <= pop ? front : '0;
        end
    end

endmodule

// File: tb/tb_ib_voq.sv
// Scoreboard bench for ib_voq: per-queue expected flit queues, popped
// against pkto of the queue currently being served.
module tb_ib_voq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pkti;
    logic        full, we, err;
    logic [15:0] pkto;
    logic [3:0]  req, ack;

    int total = 0;
    int bad   = 0;
    int srv   = -1;

    logic [15:0] mq [4][$];
    logic [15:0] tflit;

    localparam logic [1:0] HD = 2'b01, BD = 2'b10, TL = 2'b11;

    ib_voq #(.PKTW(16), .NPORT(4), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .pkti(pkti), .full(full), .we(we),
        .pkto(pkto), .req(req), .ack(ack), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] fl(input logic [1:0] fc,
                                       input logic [1:0] d,
                                       input logic [11:0] p);
        return {fc, d, p};
    endfunction

    // Every non-idle output flit must be the next one of the served queue
    always @(negedge clk) begin
        if (pkto !== 16'h0) begin
            if (srv < 0 || mq[srv].size() == 0)
                check("unexpected_pkto", pkto, 0);
            else
                check("pkto", pkto, mq[srv].pop_front());
        end
    end

    task automatic put(input logic [15:0] f, input int q);
        @(negedge clk);
        pkti = f;
        #1;
        check("we", we, 1);
        check("full", full, 0);
        mq[q].push_back(f);
    endtask

    task automatic drain(input int q, input int budget);
        for (int i = 0; i < budget && mq[q].size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("drain", mq[q].size(), 0);
    endtask

    initial begin
        rst = 1'b1; pkti = '0; ack = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_pkto", pkto, 0);
        check("rst_err", err, 0);
        check("rst_req", req, 0);
        check("rst_full", full, 0);
        check("rst_we", we, 0);

        // packet to dst 2, no grant yet
        put(fl(HD, 2'd2, 12'h101), 2);
        put(fl(BD, 2'd0, 12'h102), 2);
        check("req_after_head", req, 4'b0100);
        tflit = fl(TL, 2'd0, 12'h103);
        put(tflit, 2);
        @(negedge clk);
        pkti = '0;
        #1;
        check("req_held", req, 4'b0100);
        check("pkto_no_grant", pkto, 0);

        // grant: head appears two cycles after ack
        @(negedge clk);
        ack = 4'b0100; srv = 2;
        @(negedge clk);
        ack = '0;
        #1;
        check("pkto_lat", pkto, 0);
        repeat (3) @(negedge clk);
        #1;
        check("pkto_tail", pkto, tflit);
        @(negedge clk);
        #1;
        check("pkto_after_tail", pkto, 0);
        check("req_after_tail", req, 0);
        check("q2_empty", mq[2].size(), 0);

        // fill VOQ 1, then try a ninth flit
        put(fl(HD, 2'd1, 12'h200), 1);
        for (int i = 1; i < 7; i++)
            put(fl(BD, 2'd0, 12'(12'h200 + i)), 1);
        put(fl(TL, 2'd0, 12'h207), 1);
        @(negedge clk);
        pkti = fl(HD, 2'd1, 12'h208);
        #1;
        check("full_q1", full, 1);
        check("we_q1_full", we, 0);
        @(negedge clk);
        #1;
        check("full_q1_hold", full, 1);
        put(fl(HD, 2'd3, 12'h300), 3);
        put(fl(TL, 2'd0, 12'h301), 3);
        @(negedge clk);
        pkti = '0;
        #1;
        check("req_q1_q3", req, 4'b1010);
        ack = 4'b0010; srv = 1;
        @(negedge clk);
        ack = '0;
        drain(1, 20);

        // queues 0 and 3 compete; ack ignored while sending
        put(fl(HD, 2'd0, 12'h400), 0);
        put(fl(BD, 2'd0, 12'h401), 0);
        put(fl(TL, 2'd0, 12'h402), 0);
        @(negedge clk);
        pkti = '0;
        #1;
        check("req_q0_q3", req, 4'b1001);
        ack = 4'b1001; srv = 0;
        @(negedge clk);
        #1;
        check("req_send_q0", req, 4'b0001);
        @(negedge clk);
        #1;
        check("req_send_ack_ign", req, 4'b0001);
        @(negedge clk);
        ack = '0;
        drain(0, 20);
        check("req_q3_left", req, 4'b1000);
        @(negedge clk);
        ack = 4'b1000; srv = 3;
        @(negedge clk);
        ack = '0;
        drain(3, 20);

        // writer stalls while the connection is open
        put(fl(HD, 2'd2, 12'h500), 2);
        @(negedge clk);
        pkti = '0; ack = 4'b0100; srv = 2;
        @(negedge clk);
        ack = '0;
        put(fl(BD, 2'd0, 12'h501), 2);
        @(negedge clk);
        pkti = '0;
        #1;
        check("bubble", pkto, 0);
        check("req_hold", req, 4'b0100);
        repeat (2) @(negedge clk);
        #1;
        check("bubble2", pkto, 0);
        put(fl(BD, 2'd0, 12'h502), 2);
        @(negedge clk);
        pkti = '0;
        @(negedge clk);
        #1;
        check("req_hold2", req, 4'b0100);
        put(fl(TL, 2'd0, 12'h503), 2);
        @(negedge clk);
        pkti = '0;
        drain(2, 20);
        @(negedge clk);
        #1;
        check("req_stall_done", req, 0);

        // orphan body after reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pkti = fl(BD, 2'd1, 12'h600);
        #1;
        check("orphan_we", we, 0);
        check("orphan_full", full, 0);
        @(negedge clk);
        pkti = '0;
        #1;
        check("orphan_err", err, 1);
        @(negedge clk);
        #1;
        check("err_pulse", err, 0);

        // reset in the middle of a connection
        put(fl(HD, 2'd1, 12'h700), 1);
        put(fl(BD, 2'd0, 12'h701), 1);
        @(negedge clk);
        pkti = '0; ack = 4'b0010; srv = 1;
        @(negedge clk);
        ack = '0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_send_pkto", pkto, 0);
        check("rst_send_req", req, 0);
        mq[1].delete();
        repeat (3) @(negedge clk);
        #1;
        check("post_rst_req", req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
